aeolus_control_sequencer: RTL and testbench
===========================================

Name: aeolus_control_sequencer

Overview:
Multi-cycle control FSM that drives the datapath's load and shift strobes. It accepts one 8-bit instruction per valid/ready handshake, decodes it, and issues one-hot strobes over a fixed cycle schedule:
- LDA, LDB, LDO to the A/B/O register file;
- load and shift_state to the shift register;
- alu_op to the ALU.

It is the initiator side of the register-file and shifter load interface. It also hands result-output events to a downstream consumer over a second handshake.

Parameters:
OPCODE_WIDTH, 4, opcode field width (instr[7:4]).
IMM_WIDTH, 4, immediate/repeat-count field width (instr[3:0]); equals register-file INPUT_WIDTH.

Ports:
clk  in  1  clock, all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
instr  in  8  instruction {opcode, imm}.
instr_valid  in  1  instr is presented.
instr_ready  out  1  sequencer can accept; high only in FETCH and not reset.
imm_out  out  IMM_WIDTH  immediate driven to AIn/BIn/shifter in.
lda  out  1  load A strobe.
ldb  out  1  load B strobe.
ldo  out  1  load O strobe.
alu_op  out  2  00 add, 01 sub, others reserved (never driven).
shift_load  out  1  shifter loadEnable.
shift_state  out  2  10 LSH, 01 RSH, 00 hold.
out_valid  out  1  O register result available to consumer.
out_ready  in  1  consumer accepts result.
illegal  out  1  one-cycle pulse on undefined opcode.
halted  out  1  sequencer stopped by HLT.

Behaviour:
- Reset: state=FETCH; imm_out=0, alu_op=00, shift_state=00. lda, ldb, ldo, shift_load, out_valid, illegal and halted are all 0. instr_ready=0 while reset is high. Reset has priority over all inputs, in any state.
- Opcodes: 0 NOP, 1 LDA, 2 LDB, 3 ADD, 4 SUB, 5 LSH, 6 RSH, 7 SLD, 8 OUT, F HLT; 9-E illegal.
- States: FETCH, DECODE, EXEC, WB, OUT_WAIT, HALT.
- FETCH: instr_ready=1. On instr_valid, at edge T0 latch instr and go to DECODE. No strobes are asserted in FETCH.
- DECODE (T1):
  - imm_out <= imm, and holds until the next DECODE.
  - Load repeat counter with imm.
  - Go to EXEC.
  - No strobes.
- EXEC (T2+):
  - LDA / LDB / SLD: lda / ldb / shift_load high for exactly one cycle, then FETCH.
  - ADD / SUB: alu_op=00 / 01 in EXEC and WB. Go to WB, which asserts ldo for one cycle (ALU result settles one cycle before capture), then FETCH.
  - LSH / RSH: shift_state=10 / 01 for exactly imm consecutive cycles; the counter decrements each cycle, leave EXEC when it reaches 1. If imm=0, no shift cycle is issued, and EXEC lasts one cycle with shift_state=00.
  - NOP: one idle cycle, then FETCH.
  - OUT: go to OUT_WAIT.
  - Illegal opcode: illegal=1 for one cycle, no strobes, then FETCH.
  - HLT: go to HALT.
- OUT_WAIT:
  - out_valid=1 and held stable until out_valid&&out_ready at an edge; then out_valid=0 and state is FETCH.
  - No strobes.
  - out_ready while out_valid=0 is ignored.
- HALT: halted=1, instr_ready=0, instr_valid ignored. Exit only via reset.
- Mutual exclusion: at most one of {lda, ldb, ldo, shift_load, shift_state!=00} is active per cycle.
- alu_op: 00 in all non-arithmetic cycles.
- Throughput: a new instruction is accepted no earlier than the cycle after the last execution cycle.
  - Minimum cycle counts per instruction: 3 cycles (LDA/LDB/SLD/NOP/illegal/shift with imm=0); 4 cycles (ADD/SUB); 2+imm cycles (shifts with imm>=1).
- Reset mid-operation: all strobes are 0 from the edge at which reset is sampled. A partially issued shift sequence is abandoned, and the repeat counter is cleared.

Decomposition:
- Package aeolus_pkg holds:
  - opcode constants (OP_NOP...OP_HLT);
  - state encoding;
  - ALU_ADD / ALU_SUB;
  - SHIFT_HOLD / SHIFT_LSH / SHIFT_RSH (00 / 10 / 01), shared with the shift register and ALU.
- One sub-module: aeolus_repeat_counter.
  - IMM_WIDTH-bit down-counter with synchronous reset, load and decrement.
  - Flags: zero and last.

Test Plan:
- Reset, then instr=0x15 with valid at T0 -> imm_out=5 from T1; lda=1 only at T2; instr_ready=1 again at T3. Repeat with 0x2A -> ldb pulse, imm_out=A.
- instr=0x30, then 0x40 back-to-back -> ADD: alu_op=00 at T2–T3, ldo=1 only at T3. SUB: alu_op=01 on its EXEC/WB, ldo a single pulse; no overlap with other strobes.
- instr=0x53 -> shift_state=10 at T2, T3, T4 exactly, then 00; instr_ready at T5. instr=0x60 -> no shift strobe, ready at T3.
- instr=0x80, out_ready low for 4 cycles -> out_valid held high, instr_ready=0, no strobes. out_ready=1 -> out_valid=0 next cycle, FETCH.
- instr=0x9A -> illegal pulse at T2 only, no strobes. Then 0xF0 -> halted=1 persistently and instr_valid ignored for 10 cycles. Reset -> halted=0, FETCH.
- instr=0x57, reset asserted on the third shift cycle -> shift_state=00 and all outputs at reset values from that edge. After reset release, 0x11 executes normally with lda at T2.

Source files
------------

// File: rtl/aeolus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aeolus_pkg
// Description : Shared definitions for the aeolus control sequencer and its
//               datapath. Holds the opcode map, the sequencer state encoding,
//               the ALU operation codes and the shift-register state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package aeolus_pkg;

    localparam int OPCODE_W = 4;
    localparam int IMM_W    = 4;

    // Opcode map (instr[7:4]); 9..E are undefined.
    localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_LDB = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_LSH = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_RSH = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_SLD = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    // ALU operation select.
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    // Shift-register state select.
    localparam logic [1:0] SHIFT_HOLD = 2'b00;
    localparam logic [1:0] SHIFT_LSH  = 2'b10;
    localparam logic [1:0] SHIFT_RSH  = 2'b01;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_EXEC     = 3'd2,
        ST_WB       = 3'd3,
        ST_OUT_WAIT = 3'd4,
        ST_HALT     = 3'd5
    } state_t;

    // True for every defined opcode.
    function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
        return (op <= OP_OUT) || (op == OP_HLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aeolus_repeat_counter.sv
`default_nettype none
// ============================================================================
// Module      : aeolus_repeat_counter
// Description : Down-counter holding the remaining repeat count of a shift
//               instruction. Load has priority over decrement; decrement
//               saturates at zero.
// Ports       : clk, reset (sync, active-high)
//               load / load_value : capture a new count
//               dec               : decrement by one
//               zero              : count == 0
//               last              : count == 1 (final repeat cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module aeolus_repeat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign zero = (r_count == '0);
    assign last = (r_count == c_one);

endmodule
`default_nettype wire

// File: rtl/aeolus_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aeolus_control_sequencer
// Description : Multi-cycle control FSM. Accepts one {opcode, imm} instruction
//               per instr_valid/instr_ready handshake and issues registered
//               one-hot strobes to the register file (lda/ldb/ldo), the
//               shifter (shift_load/shift_state) and the ALU (alu_op). Result
//               events are offered downstream on out_valid/out_ready.
// Ports       : clk, reset (sync, active-high)
//               instr, instr_valid, instr_ready : instruction handshake
//               imm_out                         : immediate to datapath
//               lda, ldb, ldo, alu_op           : register file / ALU
//               shift_load, shift_state         : shift register
//               out_valid, out_ready            : result handshake
//               illegal, halted                 : status
// Revision    : 1.0 - initial release
// ============================================================================
module aeolus_control_sequencer
    import aeolus_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4,
    parameter int IMM_WIDTH    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [OPCODE_WIDTH+IMM_WIDTH-1:0] instr,
    input  logic                              instr_valid,
    output logic                              instr_ready,
    output logic [IMM_WIDTH-1:0]              imm_out,
    output logic                              lda,
    output logic                              ldb,
    output logic                              ldo,
    output logic [1:0]                        alu_op,
    output logic                              shift_load,
    output logic [1:0]                        shift_state,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              illegal,
    output logic                              halted
);

    state_t                            r_state;
    logic [OPCODE_WIDTH+IMM_WIDTH-1:0] r_instr;

    logic [OPCODE_WIDTH-1:0] w_op;
    logic [IMM_WIDTH-1:0]    w_imm;
    logic                    w_shift_op;
    logic                    w_cnt_zero;
    logic                    w_cnt_last;

    assign w_op       = r_instr[IMM_WIDTH +: OPCODE_WIDTH];
    assign w_imm      = r_instr[IMM_WIDTH-1:0];
    assign w_shift_op = (w_op == OP_LSH) || (w_op == OP_RSH);

    // Ready is gated by reset directly so no instruction can be accepted on
    // the edge that resets the sequencer.
    assign instr_ready = (r_state == ST_FETCH) && !reset;

    // Counter is loaded in DECODE so it holds imm during the first EXEC cycle;
    // it steps once per issued shift cycle.
    aeolus_repeat_counter #(
        .WIDTH (IMM_WIDTH)
    ) u_repeat_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (r_state == ST_DECODE),
        .load_value (w_imm),
        .dec        ((r_state == ST_EXEC) && w_shift_op && !w_cnt_zero),
        .zero       (w_cnt_zero),
        .last       (w_cnt_last)
    );

    // All outputs are registered: strobes for a cycle are decided on the
    // edge that enters that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_FETCH;
            r_instr     <= '0;
            imm_out     <= '0;
            lda         <= 1'b0;
            ldb         <= 1'b0;
            ldo         <= 1'b0;
            alu_op      <= ALU_ADD;
            shift_load  <= 1'b0;
            shift_state <= SHIFT_HOLD;
            out_valid   <= 1'b0;
            illegal     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_FETCH: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                        // Immediate is presented from the DECODE cycle on and
                        // held until the next instruction is accepted.
                        imm_out <= instr[IMM_WIDTH-1:0];
                        r_state <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    r_state    <= ST_EXEC;
                    lda        <= (w_op == OP_LDA);
                    ldb        <= (w_op == OP_LDB);
                    shift_load <= (w_op == OP_SLD);
                    alu_op     <= (w_op == OP_SUB) ? ALU_SUB : ALU_ADD;
                    illegal    <= !op_is_legal(w_op);
                    if (w_imm == '0) begin
                        shift_state <= SHIFT_HOLD;
                    end else if (w_op == OP_LSH) begin
                        shift_state <= SHIFT_LSH;
                    end else if (w_op == OP_RSH) begin
                        shift_state <= SHIFT_RSH;
                    end else begin
                        shift_state <= SHIFT_HOLD;
                    end
                end

                ST_EXEC: begin
                    lda        <= 1'b0;
                    ldb        <= 1'b0;
                    shift_load <= 1'b0;
                    illegal    <= 1'b0;
                    if ((w_op == OP_ADD) || (w_op == OP_SUB)) begin
                        // alu_op stays put so the result is stable when ldo
                        // captures it in WB.
                        r_state <= ST_WB;
                        ldo     <= 1'b1;
                    end else if (w_shift_op) begin
                        if (w_cnt_zero || w_cnt_last) begin
                            shift_state <= SHIFT_HOLD;
                            r_state     <= ST_FETCH;
                        end
                    end else if (w_op == OP_OUT) begin
                        r_state   <= ST_OUT_WAIT;
                        out_valid <= 1'b1;
                    end else if (w_op == OP_HLT) begin
                        r_state <= ST_HALT;
                        halted  <= 1'b1;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end

                ST_WB: begin
                    ldo     <= 1'b0;
                    alu_op  <= ALU_ADD;
                    r_state <= ST_FETCH;
                end

                ST_OUT_WAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= ST_FETCH;
                    end
                end

                ST_HALT: begin
                    r_state <= ST_HALT;
                end

                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aeolus_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aeolus_control_sequencer
// Description : Directed self-checking bench for aeolus_control_sequencer.
//               The observed vector packs the control outputs as
//               {instr_ready, lda, ldb, ldo, shift_load, shift_state[1:0],
//                alu_op[1:0], out_valid, illegal, halted}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aeolus_control_sequencer;

    localparam logic [11:0] c_none = 12'h000;
    localparam logic [11:0] c_rdy  = 12'h800;
    localparam logic [11:0] c_lda  = 12'h400;
    localparam logic [11:0] c_ldb  = 12'h200;
    localparam logic [11:0] c_ldo  = 12'h100;
    localparam logic [11:0] c_sld  = 12'h080;
    localparam logic [11:0] c_lsh  = 12'h040;
    localparam logic [11:0] c_rsh  = 12'h020;
    localparam logic [11:0] c_sub  = 12'h008;
    localparam logic [11:0] c_ov   = 12'h004;
    localparam logic [11:0] c_ill  = 12'h002;
    localparam logic [11:0] c_hlt  = 12'h001;

    logic       clk;
    logic       reset;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] imm_out;
    logic       lda, ldb, ldo;
    logic [1:0] alu_op;
    logic       shift_load;
    logic [1:0] shift_state;
    logic       out_valid;
    logic       out_ready;
    logic       illegal;
    logic       halted;

    logic [11:0] obs;
    assign obs = {instr_ready, lda, ldb, ldo, shift_load, shift_state,
                  alu_op, out_valid, illegal, halted};

    int errors = 0;
    int checks = 0;

    aeolus_control_sequencer #(
        .OPCODE_WIDTH (4),
        .IMM_WIDTH    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .imm_out     (imm_out),
        .lda         (lda),
        .ldb         (ldb),
        .ldo         (ldo),
        .alu_op      (alu_op),
        .shift_load  (shift_load),
        .shift_state (shift_state),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .illegal     (illegal),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; sampling point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in FETCH; returns sampled in the DECODE cycle.
    task automatic issue(input logic [7:0] ins);
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!instr_ready) begin
            errors++;
            $display("FAIL issue_ready instr=%h: instr_ready=%b required=1", ins, instr_ready);
        end
        instr       = ins;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        instr       = 8'h00;
        instr_valid = 1'b1;
        out_ready   = 1'b0;
        tick();
        tick();
        checks++;
        if (obs !== c_none) begin
            errors++;
            $display("FAIL reset_outputs: obs=%h required=%h", obs, c_none);
        end
        checks++;
        if (imm_out !== 4'h0) begin
            errors++;
            $display("FAIL reset_imm: imm_out=%h required=0", imm_out);
        end
        instr_valid = 1'b0;
        reset       = 1'b0;
        #1;
        checks++;
        if (obs !== c_rdy) begin
            errors++;
            $display("FAIL reset_release: obs=%h required=%h", obs, c_rdy);
        end
    endtask

    // Single-cycle instructions: DECODE, EXEC, back to FETCH.
    task automatic test_single_cycle();
        logic [7:0]  ins [0:4];
        logic [11:0] e   [0:4][0:2];
        ins = '{8'h15, 8'h2A, 8'h73, 8'h0C, 8'h9A};
        e   = '{'{c_none, c_lda,  c_rdy},
                '{c_none, c_ldb,  c_rdy},
                '{c_none, c_sld,  c_rdy},
                '{c_none, c_none, c_rdy},
                '{c_none, c_ill,  c_rdy}};
        for (int k = 0; k < 5; k++) begin
            issue(ins[k]);
            checks++;
            if (imm_out !== ins[k][3:0]) begin
                errors++;
                $display("FAIL single_imm instr=%h: imm_out=%h required=%h", ins[k], imm_out, ins[k][3:0]);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs !== e[k][i]) begin
                    errors++;
                    $display("FAIL single_seq instr=%h T%0d: obs=%h required=%h", ins[k], i + 1, obs, e[k][i]);
                end
                if (i < 2) tick();
            end
        end
    endtask

    // ADD immediately followed by SUB.
    task automatic test_back_to_back();
        logic [7:0]  ins [0:1];
        logic [11:0] e   [0:1][0:3];
        ins = '{8'h30, 8'h40};
        e   = '{'{c_none, c_none, c_ldo,         c_rdy},
                '{c_none, c_sub,  c_ldo | c_sub, c_rdy}};
        for (int k = 0; k < 2; k++) begin
            issue(ins[k]);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs !== e[k][i]) begin
                    errors++;
                    $display("FAIL arith_seq instr=%h T%0d: obs=%h required=%h", ins[k], i + 1, obs, e[k][i]);
                end
                if (i < 3) tick();
            end
        end
    endtask

    task automatic test_shift();
        logic [7:0]  ins [0:2];
        int          len [0:2];
        logic [11:0] e   [0:2][0:4];
        ins = '{8'h53, 8'h60, 8'h62};
        len = '{5, 3, 4};
        e   = '{'{c_none, c_lsh,  c_lsh, c_lsh, c_rdy},
                '{c_none, c_none, c_rdy, c_rdy, c_rdy},
                '{c_none, c_rsh,  c_rsh, c_rdy, c_rdy}};
        for (int k = 0; k < 3; k++) begin
            issue(ins[k]);
            for (int i = 0; i < len[k]; i++) begin
                checks++;
                if (obs !== e[k][i]) begin
                    errors++;
                    $display("FAIL shift_seq instr=%h T%0d: obs=%h required=%h", ins[k], i + 1, obs, e[k][i]);
                end
                if (i < len[k] - 1) tick();
            end
        end
    endtask

    task automatic test_out();
        // out_ready high before out_valid rises must be ignored.
        out_ready = 1'b1;
        issue(8'h80);
        checks++;
        if (obs !== c_none) begin
            errors++;
            $display("FAIL out_decode: obs=%h required=%h", obs, c_none);
        end
        tick();
        checks++;
        if (obs !== c_none) begin
            errors++;
            $display("FAIL out_exec: obs=%h required=%h", obs, c_none);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== c_ov) begin
                errors++;
                $display("FAIL out_hold cycle%0d: obs=%h required=%h", i, obs, c_ov);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (obs !== c_rdy) begin
            errors++;
            $display("FAIL out_done: obs=%h required=%h", obs, c_rdy);
        end
    endtask

    task automatic test_halt();
        issue(8'hF0);
        tick();
        checks++;
        if (obs !== c_none) begin
            errors++;
            $display("FAIL halt_exec: obs=%h required=%h", obs, c_none);
        end
        instr       = 8'h15;
        instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs !== c_hlt) begin
                errors++;
                $display("FAIL halt_hold cycle%0d: obs=%h required=%h", i, obs, c_hlt);
            end
        end
        instr_valid = 1'b0;
        reset       = 1'b1;
        tick();
        checks++;
        if (obs !== c_none) begin
            errors++;
            $display("FAIL halt_reset: obs=%h required=%h", obs, c_none);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== c_rdy) begin
            errors++;
            $display("FAIL halt_release: obs=%h required=%h", obs, c_rdy);
        end
    endtask

    task automatic test_reset_mid_shift();
        issue(8'h57);
        tick();
        tick();
        tick();
        checks++;
        if (obs !== c_lsh) begin
            errors++;
            $display("FAIL midreset_third_shift: obs=%h required=%h", obs, c_lsh);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (obs !== c_none || imm_out !== 4'h0) begin
            errors++;
            $display("FAIL midreset_clear: obs=%h imm=%h required=%h imm=0", obs, imm_out, c_none);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (obs !== c_rdy) begin
            errors++;
            $display("FAIL midreset_idle: obs=%h required=%h", obs, c_rdy);
        end
        issue(8'h11);
        checks++;
        if (obs !== c_none || imm_out !== 4'h1) begin
            errors++;
            $display("FAIL midreset_lda_t1: obs=%h imm=%h required=%h imm=1", obs, imm_out, c_none);
        end
        tick();
        checks++;
        if (obs !== c_lda) begin
            errors++;
            $display("FAIL midreset_lda_t2: obs=%h required=%h", obs, c_lda);
        end
        tick();
        checks++;
        if (obs !== c_rdy) begin
            errors++;
            $display("FAIL midreset_lda_t3: obs=%h required=%h", obs, c_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_back_to_back();
        test_shift();
        test_out();
        test_halt();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
